// File: rtl/rr_bus_arbiter_3.sv
// Three-way bus arbiter with registered one-hot grant, encoded owner, bounded hold time and lock.
// Round-robin or fixed-priority selection; grant hands over directly between owners without idle gaps.
module rr_bus_arbiter_3 #(
  parameter int unsigned MaxHold   = 8,
  parameter bit          FixedPrio = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req_1,
  input  logic       Req_2,
  input  logic       Req_3,
  input  logic       Lock,
  output logic       Grant_1,
  output logic       Grant_2,
  output logic       Grant_3,
  output logic [1:0] Owner,
  output logic       Busy,
  output logic [7:0] HoldCnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam bit         HOLD_EN   = (MaxHold != 0);
  localparam logic [7:0] HOLD_LIM  = 8'(MaxHold);
  localparam logic [7:0] HOLD_SAT  = 8'hFF;
  localparam logic [1:0] ID_NONE   = 2'd0;
  localparam logic [1:0] ID_FIRST  = 2'd1;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] hold_q,  hold_d;
  logic [1:0] ptr_q,   ptr_d;

  logic [2:0] req;
  logic [2:0] owner_mask;
  logic [2:0] others;
  logic [1:0] search_start;
  logic [1:0] win_any;
  logic [1:0] win_other;
  logic       owner_req;
  logic       others_pending;
  logic       hold_expired;
  logic       preempt;

  // First set bit of c when scanning requester ids start, start+1, start+2 (mod 3, ids 1..3).
  function automatic logic [1:0] pick(input logic [2:0] c, input logic [1:0] start);
    logic [1:0] p;
    p = ID_NONE;
    case (start)
      2'd2: begin
        if      (c[1]) p = 2'd2;
        else if (c[2]) p = 2'd3;
        else if (c[0]) p = 2'd1;
      end
      2'd3: begin
        if      (c[2]) p = 2'd3;
        else if (c[0]) p = 2'd1;
        else if (c[1]) p = 2'd2;
      end
      default: begin
        if      (c[0]) p = 2'd1;
        else if (c[1]) p = 2'd2;
        else if (c[2]) p = 2'd3;
      end
    endcase
    return p;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] w);
    logic [1:0] n;
    case (w)
      2'd1:    n = 2'd2;
      2'd2:    n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] decode(input logic [1:0] id);
    logic [2:0] m;
    m = '0;
    case (id)
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b010;
      2'd3:    m = 3'b100;
      default: m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    req            = {Req_3, Req_2, Req_1};
    owner_mask     = decode(owner_q);
    others         = req & ~owner_mask;
    owner_req      = |(req & owner_mask);
    others_pending = |others;
    search_start   = FixedPrio ? ID_FIRST : ptr_q;
    win_any        = pick(req, search_start);
    win_other      = pick(others, search_start);
    hold_expired   = HOLD_EN && (hold_q >= HOLD_LIM);
    preempt        = hold_expired && !Lock && others_pending;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= ID_NONE;
      hold_q  <= '0;
      ptr_q   <= ID_FIRST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWNED;
          owner_d = win_any;
          hold_d  = 8'd1;
          ptr_d   = next_ptr(win_any);
        end
      end
      OWNED: begin
        if (owner_req) begin
          if (preempt) begin
            owner_d = win_other;
            hold_d  = 8'd1;
            ptr_d   = next_ptr(win_other);
          end else if (hold_q != HOLD_SAT) begin
            hold_d  = hold_q + 8'd1;
          end
        end else if (others_pending) begin
          // Release with someone waiting: hand over without passing through IDLE.
          owner_d = win_other;
          hold_d  = 8'd1;
          ptr_d   = next_ptr(win_other);
        end else begin
          state_d = IDLE;
          owner_d = ID_NONE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = ID_NONE;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    {Grant_3, Grant_2, Grant_1} = decode(owner_q);
    Owner   = owner_q;
    Busy    = (state_q == OWNED);
    HoldCnt = hold_q;
  end

endmodule

// File: tb/tb_rr_bus_arbiter_3.sv
// Bench for rr_bus_arbiter_3: three parameterisations share one stimulus stream and are
// compared every cycle against an integer-level model, plus directed literal checks.
module tb_rr_bus_arbiter_3;

  localparam int NI = 3;
  localparam int unsigned MH [NI] = '{8, 4, 0};
  localparam bit          FP [NI] = '{1'b0, 1'b1, 1'b0};
  localparam string       NM [NI] = '{"A", "B", "C"};

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Req_1 = 1'b0, Req_2 = 1'b0, Req_3 = 1'b0, Lock = 1'b0;

  logic [2:0] gnt [NI];
  logic [1:0] own [NI];
  logic       bsy [NI];
  logic [7:0] hc  [NI];

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic g1, g2, g3, b;
    logic [1:0] o;
    logic [7:0] h;
    rr_bus_arbiter_3 #(.MaxHold(MH[gi]), .FixedPrio(FP[gi])) u_dut (
      .Clock(Clock), .Reset(Reset),
      .Req_1(Req_1), .Req_2(Req_2), .Req_3(Req_3), .Lock(Lock),
      .Grant_1(g1), .Grant_2(g2), .Grant_3(g3),
      .Owner(o), .Busy(b), .HoldCnt(h)
    );
    assign gnt[gi] = {g3, g2, g1};
    assign own[gi] = o;
    assign bsy[gi] = b;
    assign hc[gi]  = h;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: owner id 0..3, hold count, round-robin start id 1..3.
  int m_owner [NI];
  int m_hold  [NI];
  int m_ptr   [NI];

  function automatic int search(input int i, input bit r [4], input int excl);
    int start, c;
    start = FP[i] ? 1 : m_ptr[i];
    for (int k = 0; k < 3; k++) begin
      c = ((start - 1 + k) % 3) + 1;
      if (r[c] && c != excl) return c;
    end
    return 0;
  endfunction

  function automatic void take(input int i, input int w);
    m_owner[i] = w;
    m_hold[i]  = 1;
    m_ptr[i]   = (w % 3) + 1;
  endfunction

  function automatic void model_step(input int i, input bit r [4], input bit lk);
    int w;
    if (m_owner[i] == 0) begin
      w = search(i, r, 0);
      if (w != 0) take(i, w);
    end else begin
      w = search(i, r, m_owner[i]);
      if (r[m_owner[i]]) begin
        if (MH[i] != 0 && m_hold[i] >= int'(MH[i]) && !lk && w != 0) take(i, w);
        else if (m_hold[i] < 255) m_hold[i]++;
      end else if (w != 0) begin
        take(i, w);
      end else begin
        m_owner[i] = 0;
        m_hold[i]  = 0;
      end
    end
  endfunction

  always @(posedge Clock or posedge Reset) begin
    bit r [4];
    r = '{1'b0, Req_1, Req_2, Req_3};
    for (int i = 0; i < NI; i++) begin
      if (Reset) begin
        m_owner[i] = 0;
        m_hold[i]  = 0;
        m_ptr[i]   = 1;
      end else begin
        model_step(i, r, Lock);
      end
    end
  end

  always @(negedge Clock) begin
    int eg;
    for (int i = 0; i < NI; i++) begin
      eg = (m_owner[i] == 0) ? 0 : (1 << (m_owner[i] - 1));
      chk({NM[i], ".grant"},   int'(gnt[i]), eg);
      chk({NM[i], ".owner"},   int'(own[i]), m_owner[i]);
      chk({NM[i], ".busy"},    int'(bsy[i]), (m_owner[i] != 0) ? 1 : 0);
      chk({NM[i], ".holdcnt"}, int'(hc[i]),  m_hold[i]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic set_req(input bit a, input bit b, input bit c);
    Req_1 = a; Req_2 = b; Req_3 = c;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    set_req(0, 0, 0);
    Lock = 1'b0;
    cyc(1);
    Reset = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("reset.grant", int'(gnt[0]), 0);
    chk("reset.owner", int'(own[0]), 0);
    chk("reset.busy",  int'(bsy[0]), 0);
    chk("reset.hold",  int'(hc[0]),  0);

    // First grant: one cycle of latency.
    Reset = 1'b0;
    set_req(0, 1, 0);
    chk("lat.pre_grant", int'(gnt[0]), 0);
    cyc(1);
    chk("lat.grant2", int'(gnt[0]), 3'b010);
    chk("lat.owner",  int'(own[0]), 2);
    chk("lat.busy",   int'(bsy[0]), 1);
    chk("lat.hold",   int'(hc[0]),  1);

    // All requesting: rotation 1,2,3,1 with 8 cycles each, no gaps.
    do_reset();
    set_req(1, 1, 1);
    for (int k = 0; k < 32; k++) begin
      cyc(1);
      chk("rot.owner", int'(own[0]), ((k / 8) % 3) + 1);
      chk("rot.hold",  int'(hc[0]),  (k % 8) + 1);
    end

    // Lock holds owner 1 against a waiting requester 3.
    do_reset();
    set_req(1, 0, 0);
    cyc(1);
    Lock = 1'b1;
    Req_3 = 1'b1;
    cyc(19);
    chk("lock.owner", int'(own[0]), 1);
    chk("lock.hold",  int'(hc[0]),  20);
    Lock = 1'b0;
    cyc(1);
    chk("unlock.grant3", int'(gnt[0]), 3'b100);
    chk("unlock.hold",   int'(hc[0]),  1);

    // Release handover then release to idle.
    do_reset();
    set_req(0, 1, 0);
    cyc(1);
    Req_1 = 1'b1;
    cyc(1);
    Req_2 = 1'b0;
    cyc(1);
    chk("rel.owner1", int'(own[0]), 1);
    chk("rel.hold",   int'(hc[0]),  1);
    Req_1 = 1'b0;
    cyc(1);
    chk("rel.idle_owner", int'(own[0]), 0);
    chk("rel.idle_busy",  int'(bsy[0]), 0);

    // Fixed priority, MaxHold=4 instance.
    do_reset();
    set_req(0, 1, 0);
    cyc(1);
    chk("fix.owner2", int'(own[1]), 2);
    Req_3 = 1'b1;
    cyc(4);
    chk("fix.owner3", int'(own[1]), 3);
    Req_1 = 1'b1;
    cyc(4);
    chk("fix.owner1", int'(own[1]), 1);

    // Hold counter saturation.
    do_reset();
    set_req(1, 0, 0);
    cyc(300);
    chk("sat.hold",  int'(hc[0]),  255);
    chk("sat.owner", int'(own[0]), 1);

    // Asynchronous reset in mid-cycle while requester 3 owns the bus.
    do_reset();
    set_req(0, 0, 1);
    cyc(1);
    chk("arst.pre_grant3", int'(gnt[0]), 3'b100);
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("arst.grant", int'(gnt[0]), 0);
    chk("arst.owner", int'(own[0]), 0);
    chk("arst.busy",  int'(bsy[0]), 0);
    chk("arst.hold",  int'(hc[0]),  0);
    set_req(1, 1, 1);
    cyc(1);
    Reset = 1'b0;
    cyc(1);
    chk("arst.first_grant1", int'(gnt[0]), 3'b001);

    // Randomised traffic with occasional lock and mid-cycle resets.
    for (int n = 0; n < 4000; n++) begin
      if (Req_1) Req_1 = ($urandom_range(0, 7) != 0); else Req_1 = ($urandom_range(0, 3) == 0);
      if (Req_2) Req_2 = ($urandom_range(0, 7) != 0); else Req_2 = ($urandom_range(0, 3) == 0);
      if (Req_3) Req_3 = ($urandom_range(0, 7) != 0); else Req_3 = ($urandom_range(0, 3) == 0);
      Lock = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
